// File: rtl/excess3_serial_decoder_if.sv
// ---------------------------------------------------------------------------
// excess3_serial_decoder_if
// Bundles the serial input and the decoded outputs of the Excess-3 serial
// decoder so that producer and decoder can be connected with one port.
//
// Signals:
//   X      serial Excess-3 data bit, LSB first   (master -> slave)
//   EN     bit-valid qualifier                   (master -> slave)
//   S      serial BCD bit, Mealy                 (slave -> master)
//   V      invalid-code flag on bit 3, Mealy     (slave -> master)
//   ERR    sticky invalid-code flag              (slave -> master)
//   DIGIT  last decoded BCD digit, parallel      (slave -> master)
//   DVALID one-cycle strobe, DIGIT updated       (slave -> master)
//
// Modports: master = bit producer, slave = decoder.
// ---------------------------------------------------------------------------
interface excess3_serial_decoder_if;
   logic       X;
   logic       EN;
   logic       S;
   logic       V;
   logic       ERR;
   logic [3:0] DIGIT;
   logic       DVALID;

   modport master (
      output X, EN,
      input  S, V, ERR, DIGIT, DVALID
   );

   modport slave (
      input  X, EN,
      output S, V, ERR, DIGIT, DVALID
   );
endinterface

// File: rtl/excess3_serial_decoder.sv
// ---------------------------------------------------------------------------
// excess3_serial_decoder
// Serial Excess-3 to BCD decoder. Consumes one code bit per falling CLK edge
// (when EN=1), LSB first, and produces the BCD bit in the same cycle as a
// Mealy output by serially subtracting 0011 with a ripple borrow. Words
// outside 0011..1100 raise V on bit 3 and set the sticky ERR flag.
//
// Ports:
//   CLK  in   clock, all state updates on the falling edge
//   RST  in   asynchronous active-high reset
//   bus  slave modport of excess3_serial_decoder_if (X, EN in;
//        S, V, ERR, DIGIT, DVALID out)
//
// Configuration:
//   E3DEC_PARALLEL_EN  defined   -> decoded bits are captured and DIGIT /
//                                   DVALID present each completed word.
//                      undefined -> no capture register; DIGIT=0, DVALID=0.
// ---------------------------------------------------------------------------
module excess3_serial_decoder (
   input  logic                      CLK,
   input  logic                      RST,
   excess3_serial_decoder_if.slave   bus
);

   // Bit position within the current code word.
   typedef enum logic [1:0] {
      POS0 = 2'd0,
      POS1 = 2'd1,
      POS2 = 2'd2,
      POS3 = 2'd3
   } pos_e;

   pos_e       pos_q, pos_d;
   logic       b_q, b_d;          // borrow out of the previous bit
   logic [2:0] code_q, code_d;    // received code bits 0..2
   logic       err_q, err_d;

   logic       k;                 // subtrahend bit of 0011 at this position
   logic       s;
   logic       v;
   logic       last_bit;
   logic [3:0] word;
   logic [1:0] pos_bits;

   assign pos_bits = pos_q;
   assign k        = (pos_q == POS0) || (pos_q == POS1);
   assign last_bit = (pos_q == POS3);
   assign s        = bus.EN & (bus.X ^ k ^ b_q);
   // Full received word is only complete while bit 3 is on the wire.
   assign word     = {bus.X, code_q};
   assign v        = bus.EN & last_bit & ((word < 4'd3) | (word > 4'd12));

   // State register.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         pos_q  <= POS0;
         b_q    <= 1'b0;
         code_q <= 3'b000;
         err_q  <= 1'b0;
      end else begin
         pos_q  <= pos_d;
         b_q    <= b_d;
         code_q <= code_d;
         err_q  <= err_d;
      end
   end

   // Next-state logic: everything holds while EN=0.
   always_comb begin
      pos_d = pos_q;
      b_d   = b_q;
      err_d = err_q | v;
      if (bus.EN) begin
         case (pos_q)
            POS0:    pos_d = POS1;
            POS1:    pos_d = POS2;
            POS2:    pos_d = POS3;
            default: pos_d = POS0;
         endcase
         // Borrow restarts at zero for the next word.
         if (last_bit) begin
            b_d = 1'b0;
         end else begin
            b_d = (~bus.X & (k | b_q)) | (k & b_q);
         end
      end
   end

`ifdef E3DEC_PARALLEL_EN
   logic [2:0] sh_q, sh_d;        // decoded bits 0..2 of the current word
   logic [3:0] digit_q, digit_d;
   logic       dvalid_q, dvalid_d;
`endif

   // Per-bit capture of the received code (and decoded) bits at their position.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cap
         assign code_d[gi] = (bus.EN && (pos_bits == 2'(gi))) ? bus.X : code_q[gi];
`ifdef E3DEC_PARALLEL_EN
         assign sh_d[gi]   = (bus.EN && (pos_bits == 2'(gi))) ? s : sh_q[gi];
`endif
      end
   endgenerate

`ifdef E3DEC_PARALLEL_EN
   // Invalid words are delivered too; ERR/V tell the consumer.
   always_comb begin
      digit_d  = digit_q;
      dvalid_d = bus.EN & last_bit;
      if (bus.EN && last_bit) begin
         digit_d = {s, sh_q};
      end
   end

   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         sh_q     <= 3'b000;
         digit_q  <= 4'b0000;
         dvalid_q <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         digit_q  <= digit_d;
         dvalid_q <= dvalid_d;
      end
   end

   assign bus.DIGIT  = digit_q;
   assign bus.DVALID = dvalid_q;
`else
   assign bus.DIGIT  = 4'b0000;
   assign bus.DVALID = 1'b0;
`endif

   assign bus.S   = s;
   assign bus.V   = v;
   assign bus.ERR = err_q;

endmodule
